data_sram_slave: RTL and testbench

- SRAM-like data-memory responder for the pipelined CPU's data port.
- Accepts load/store requests issued by the EXE side (req/addr_ok handshake) and returns completion (data_ok + rdata) to the MEM side after a fixed, parameterised latency.
- Supports multiple outstanding requests, completed in order.
- Serves as the memory model for pipeline bring-up and as the reference target for the request/response protocol.

---
 rtl/data_sram_slave_pkg.sv | 25 ++
 rtl/data_sram_slave_resp_queue.sv | 62 ++++++
 rtl/data_sram_slave.sv | 58 +++++
 tb/tb_data_sram_slave.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_slave_pkg.sv
// data_sram_slave_pkg: shared encodings, request-bus layout and defaults for the data SRAM port.
package data_sram_slave_pkg;
   localparam int DEFAULT_DEPTH_LOG2 = 10;
   localparam int CNT_W = 3;
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_e;
   // Request bus field order, MSB first: wr, size, wstrb, addr, wdata.
   typedef struct packed {
      logic        wr;
      size_e       size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_bus_t;
   localparam int DATA_SRAM_REQ_BUS_WIDTH = $bits(req_bus_t);
   function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/data_sram_slave_resp_queue.sv
// data_sram_resp_queue: in-order response FIFO; each entry counts down from LATENCY-1 and is
// presented at the head once its countdown reaches zero.
module data_sram_resp_queue
   import data_sram_slave_pkg::*;
#(
   parameter int OUTSTANDING = 2,
   parameter int LATENCY     = 2,
   parameter int COUNT_W     = $clog2(OUTSTANDING + 1)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               push_i,
   input  logic               push_wr_i,
   input  logic [31:0]        push_data_i,
   input  logic               pop_i,
   output logic               head_ready_o,
   output logic               head_wr_o,
   output logic [31:0]        head_data_o,
   output logic [COUNT_W-1:0] count_o
);
   localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
   logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               wr_q   [OUTSTANDING];
   logic [31:0]        data_q [OUTSTANDING];
   logic [CNT_W-1:0]   cd_q   [OUTSTANDING];
   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return p == PW'(OUTSTANDING - 1) ? '0 : p + 1'b1;
   endfunction
   always_comb begin
      head_d  = pop_i ? wrap_inc(head_q) : head_q;
      tail_d  = push_i ? wrap_inc(tail_q) : tail_q;
      count_d = count_q + COUNT_W'(push_i) - COUNT_W'(pop_i);
   end
   // All countdowns tick every cycle; idle slots are overwritten on push, so their value is irrelevant.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int k = 0; k < OUTSTANDING; k++) begin
            wr_q[k]   <= 1'b0;
            data_q[k] <= '0;
            cd_q[k]   <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int k = 0; k < OUTSTANDING; k++) cd_q[k] <= cd_q[k] == '0 ? '0 : cd_q[k] - 1'b1;
         if (push_i) begin
            wr_q[tail_q]   <= push_wr_i;
            data_q[tail_q] <= push_data_i;
            cd_q[tail_q]   <= CNT_W'(LATENCY - 1);
         end
      end
   end
   assign head_ready_o = count_q != '0 && cd_q[head_q] == '0;
   assign head_wr_o    = wr_q[head_q];
   assign head_data_o  = data_q[head_q];
   assign count_o      = count_q;
endmodule

// File: rtl/data_sram_slave.sv
// data_sram_slave: word-addressed data memory behind a req/addr_ok, data_ok handshake with
// fixed latency and up to OUTSTANDING in-flight requests completed in order.
module data_sram_slave
   import data_sram_slave_pkg::*;
#(
   parameter int DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
   parameter int LATENCY     = 2,
   parameter int OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata
);
   localparam int CW = $clog2(OUTSTANDING + 1);
   req_bus_t              req_bus;
   logic [31:0]           mem_q [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] idx;
   logic                  accept, head_ready, head_wr;
   logic [31:0]           head_data;
   logic [CW-1:0]         count;
   logic                  unused_ok;
   assign req_bus = '{wr: data_sram_wr, size: size_e'(data_sram_size), wstrb: data_sram_wstrb,
                      addr: data_sram_addr, wdata: data_sram_wdata};
   assign idx               = req_bus.addr[DEPTH_LOG2+1:2];
   assign data_sram_addr_ok = count < CW'(OUTSTANDING);
   assign accept            = data_sram_req && data_sram_addr_ok;
   assign data_sram_data_ok = head_ready;
   assign data_sram_rdata   = head_ready && !head_wr ? head_data : 32'h0;
   // Size is recorded on the bus only; upper and sub-word address bits alias away.
   assign unused_ok = ^{req_bus.size, req_bus.addr[31:DEPTH_LOG2+2], req_bus.addr[1:0]};
   always_ff @(posedge clk) begin
      if (accept && req_bus.wr) mem_q[idx] <= lane_merge(mem_q[idx], req_bus.wdata, req_bus.wstrb);
   end
   data_sram_resp_queue #(
      .OUTSTANDING(OUTSTANDING),
      .LATENCY    (LATENCY),
      .COUNT_W    (CW)
   ) u_queue (
      .clk         (clk),
      .resetn      (resetn),
      .push_i      (accept),
      .push_wr_i   (req_bus.wr),
      .push_data_i (req_bus.wr ? 32'h0 : mem_q[idx]),
      .pop_i       (head_ready),
      .head_ready_o(head_ready),
      .head_wr_o   (head_wr),
      .head_data_o (head_data),
      .count_o     (count)
   );
endmodule

// File: tb/tb_data_sram_slave.sv
// tb_data_sram_slave: directed scenarios plus a randomized stream checked against a
// timestamp-based reference model of the data SRAM responder.
module tb_data_sram_slave;
   localparam int LATENCY = 2, OUTSTANDING = 2, DL = 10;
   logic        clk = 0, resetn = 0, data_sram_req = 0, data_sram_wr = 0;
   logic [1:0]  data_sram_size = 2;
   logic [3:0]  data_sram_wstrb = 0;
   logic [31:0] data_sram_addr = 0, data_sram_wdata = 0;
   logic        data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   int total = 0, bad = 0, ecount = 0, obs_cnt = 0;
   typedef struct {int due; logic wr; logic [31:0] data; bit known;} ent_t;
   ent_t        q[$];
   logic [31:0] ref_mem [1<<DL];
   bit          known_w [1<<DL];
   logic        exp_aok = 1, exp_dok = 0;
   logic [31:0] exp_rd = 0;
   bit          exp_rdk = 1;

   always #5 clk = ~clk;

   data_sram_slave #(.DEPTH_LOG2(DL), .LATENCY(LATENCY), .OUTSTANDING(OUTSTANDING)) dut (
      .clk(clk), .resetn(resetn), .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata));

   function automatic void model_reset();
      q.delete();
      exp_aok = 1; exp_dok = 0; exp_rd = 0; exp_rdk = 1;
   endfunction

   // Each accepted request completes in the cycle following edge (accept_edge + LATENCY - 1).
   function automatic void model_edge();
      int i;
      ent_t e;
      ecount++;
      if (!resetn) begin
         model_reset();
         return;
      end
      if (q.size() > 0 && q[0].due < ecount) q.delete(0);
      if (data_sram_req && exp_aok) begin
         i = int'(data_sram_addr[DL+1:2]);
         if (data_sram_wr) begin
            for (int b = 0; b < 4; b++) if (data_sram_wstrb[b]) ref_mem[i][8*b +: 8] = data_sram_wdata[8*b +: 8];
            known_w[i] = known_w[i] || data_sram_wstrb == 4'hF;
         end
         e.due = ecount + LATENCY - 1;
         e.wr = data_sram_wr;
         e.data = data_sram_wr ? 32'h0 : ref_mem[i];
         e.known = data_sram_wr || known_w[i];
         q.push_back(e);
      end
      exp_aok = q.size() < OUTSTANDING;
      exp_dok = 0; exp_rd = 0; exp_rdk = 1;
      if (q.size() > 0 && q[0].due <= ecount) begin
         exp_dok = 1;
         exp_rd = q[0].wr ? 32'h0 : q[0].data;
         exp_rdk = q[0].known;
      end
   endfunction

   task automatic tick();
      if (resetn) obs_cnt += int'(data_sram_req && data_sram_addr_ok) - int'(data_sram_data_ok);
      @(posedge clk);
      model_edge();
      #1;
      if (!resetn) obs_cnt = 0;
      total++;
      assert (obs_cnt >= 0 && obs_cnt <= OUTSTANDING)
      else begin
         bad++;
         $display("FAIL outstanding_bound got=%0d max=%0d", obs_cnt, OUTSTANDING);
      end
   endtask

   task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output int lat, output bit ok);
      data_sram_req = 1; data_sram_wr = w; data_sram_addr = a; data_sram_wdata = d; data_sram_wstrb = s;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = data_sram_addr_ok;
         tick();
      end
      data_sram_req = 0;
      lat = 1;
      while (data_sram_data_ok !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      rd = data_sram_rdata;
      tick();
   endtask

   task automatic test_reset();
      resetn = 0;
      model_reset();
      for (int c = 0; c < 7; c++) begin
         if (c == 3) resetn = 1;
         tick();
         total += 3;
         if (data_sram_addr_ok !== 1'b1) begin bad++; $display("FAIL reset_addr_ok cyc=%0d got=%b exp=1", c, data_sram_addr_ok); end
         if (data_sram_data_ok !== 1'b0) begin bad++; $display("FAIL reset_data_ok cyc=%0d got=%b exp=0", c, data_sram_data_ok); end
         if (data_sram_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata cyc=%0d got=%h exp=0", c, data_sram_rdata); end
      end
   endtask

   task automatic test_word();
      logic [31:0] rd; int lat; bit ok;
      do_req(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, rd, lat, ok);
      total += 3;
      if (!ok) begin bad++; $display("FAIL word_store_accept got=0 exp=1"); end
      if (lat != LATENCY) begin bad++; $display("FAIL word_store_latency got=%0d exp=%0d", lat, LATENCY); end
      if (rd !== 32'h0) begin bad++; $display("FAIL word_store_rdata got=%h exp=0", rd); end
      do_req(1'b0, 32'h1000, 32'h0, 4'h0, rd, lat, ok);
      total += 2;
      if (lat != LATENCY) begin bad++; $display("FAIL word_load_latency got=%0d exp=%0d", lat, LATENCY); end
      if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_load_rdata got=%h exp=deadbeef", rd); end
   endtask

   task automatic test_byte_merge();
      logic [31:0] rd; int lat; bit ok;
      do_req(1'b1, 32'h1001, 32'h0000AB00, 4'b0010, rd, lat, ok);
      do_req(1'b0, 32'h1000, 32'h0, 4'h0, rd, lat, ok);
      total += 2;
      if (lat != LATENCY) begin bad++; $display("FAIL merge_latency got=%0d exp=%0d", lat, LATENCY); end
      if (rd !== 32'hDEADABEF) begin bad++; $display("FAIL merge_rdata got=%h exp=deadabef", rd); end
   endtask

   task automatic test_alias();
      logic [31:0] rd; int lat; bit ok;
      do_req(1'b1, 32'h0000_0008, 32'h12345678, 4'hF, rd, lat, ok);
      do_req(1'b0, 32'h0000_1008, 32'h0, 4'h0, rd, lat, ok);
      total += 1;
      if (rd !== 32'h12345678) begin bad++; $display("FAIL alias_rdata got=%h exp=12345678", rd); end
      do_req(1'b1, 32'hFFFF_F008, 32'hFFFFFFFF, 4'h0, rd, lat, ok);
      total += 2;
      if (lat != LATENCY) begin bad++; $display("FAIL nostrb_latency got=%0d exp=%0d", lat, LATENCY); end
      if (rd !== 32'h0) begin bad++; $display("FAIL nostrb_rdata got=%h exp=0", rd); end
      do_req(1'b0, 32'h0000_0008, 32'h0, 4'h0, rd, lat, ok);
      total += 1;
      if (rd !== 32'h12345678) begin bad++; $display("FAIL nostrb_keep got=%h exp=12345678", rd); end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd, addrs [3], words [3];
      logic [31:0] got[$];
      int lat, n, acc_e [3];
      bit ok, stalled, a;
      addrs = '{32'h1000, 32'h0008, 32'h1004};
      words = '{32'hDEADABEF, 32'h12345678, 32'hCAFEF00D};
      do_req(1'b1, 32'h1004, 32'hCAFEF00D, 4'hF, rd, lat, ok);
      n = 0; stalled = 0;
      data_sram_wr = 0; data_sram_req = 1; data_sram_addr = addrs[0];
      for (int c = 0; c < 12; c++) begin
         total += 3;
         if (data_sram_addr_ok !== exp_aok) begin bad++; $display("FAIL bp_addr_ok cyc=%0d got=%b exp=%b", c, data_sram_addr_ok, exp_aok); end
         if (data_sram_data_ok !== exp_dok) begin bad++; $display("FAIL bp_data_ok cyc=%0d got=%b exp=%b", c, data_sram_data_ok, exp_dok); end
         if (data_sram_rdata !== exp_rd) begin bad++; $display("FAIL bp_rdata cyc=%0d got=%h exp=%h", c, data_sram_rdata, exp_rd); end
         if (data_sram_data_ok === 1'b1) got.push_back(data_sram_rdata);
         if (data_sram_req && !data_sram_addr_ok) stalled = 1;
         a = data_sram_req && data_sram_addr_ok;
         tick();
         if (a && n < 3) begin
            acc_e[n] = ecount;
            n++;
            if (n == 3) data_sram_req = 0;
            else data_sram_addr = addrs[n];
         end
      end
      total += 5;
      if (n != 3) begin bad++; $display("FAIL bp_accepts got=%0d exp=3", n); end
      if (!stalled) begin bad++; $display("FAIL bp_stall got=0 exp=1"); end
      if (n == 3 && acc_e[1] - acc_e[0] != 1) begin bad++; $display("FAIL bp_consecutive got=%0d exp=1", acc_e[1] - acc_e[0]); end
      if (n == 3 && acc_e[2] - acc_e[0] != 3) begin bad++; $display("FAIL bp_third_gap got=%0d exp=3", acc_e[2] - acc_e[0]); end
      if (got.size() != 3) begin bad++; $display("FAIL bp_pulses got=%0d exp=3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         total++;
         if (got[i] !== words[i]) begin bad++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], words[i]); end
      end
   endtask

   task automatic test_random();
      logic [31:0] rd; int lat, acc_n, done_n, issued; bit ok, a;
      for (int i = 0; i < 16; i++) do_req(1'b1, 32'h200 + 32'(i * 4), $urandom, 4'hF, rd, lat, ok);
      acc_n = 0; done_n = 0; issued = 0;
      data_sram_req = 0;
      for (int c = 0; c < 2000 && (issued < 150 || done_n < acc_n || data_sram_req); c++) begin
         total += 3;
         if (data_sram_addr_ok !== exp_aok) begin bad++; $display("FAIL rnd_addr_ok cyc=%0d got=%b exp=%b", c, data_sram_addr_ok, exp_aok); end
         if (data_sram_data_ok !== exp_dok) begin bad++; $display("FAIL rnd_data_ok cyc=%0d got=%b exp=%b", c, data_sram_data_ok, exp_dok); end
         if (exp_rdk && data_sram_rdata !== exp_rd) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, data_sram_rdata, exp_rd); end
         if (data_sram_data_ok === 1'b1) done_n++;
         a = data_sram_req && data_sram_addr_ok;
         if (a) acc_n++;
         tick();
         if (a || !data_sram_req) begin
            if (issued < 150 && $urandom_range(0, 3) != 0) begin
               data_sram_req = 1;
               data_sram_wr = 1'($urandom_range(0, 1));
               data_sram_wstrb = 4'($urandom);
               data_sram_wdata = $urandom;
               data_sram_size = 2'($urandom_range(0, 2));
               data_sram_addr = ($urandom & 32'hFFFF_F003) | 32'h200 | (32'($urandom_range(0, 15)) << 2);
               issued++;
            end else data_sram_req = 0;
         end
      end
      total += 2;
      if (acc_n != 150) begin bad++; $display("FAIL rnd_accepts got=%0d exp=150", acc_n); end
      if (done_n != acc_n) begin bad++; $display("FAIL rnd_completions got=%0d exp=%0d", done_n, acc_n); end
   endtask

   task automatic test_midreset();
      logic [31:0] rd; int lat; bit ok;
      data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1000;
      total++;
      if (data_sram_addr_ok !== 1'b1) begin bad++; $display("FAIL mid_accept0 got=%b exp=1", data_sram_addr_ok); end
      tick();
      data_sram_addr = 32'h0008;
      total++;
      if (data_sram_addr_ok !== 1'b1) begin bad++; $display("FAIL mid_accept1 got=%b exp=1", data_sram_addr_ok); end
      tick();
      data_sram_req = 0;
      resetn = 0;
      model_reset();
      obs_cnt = 0;
      #1;
      for (int c = 0; c < 9; c++) begin
         if (c == 3) resetn = 1;
         total += 3;
         if (data_sram_addr_ok !== 1'b1) begin bad++; $display("FAIL mid_addr_ok cyc=%0d got=%b exp=1", c, data_sram_addr_ok); end
         if (data_sram_data_ok !== 1'b0) begin bad++; $display("FAIL mid_data_ok cyc=%0d got=%b exp=0", c, data_sram_data_ok); end
         if (data_sram_rdata !== 32'h0) begin bad++; $display("FAIL mid_rdata cyc=%0d got=%h exp=0", c, data_sram_rdata); end
         tick();
      end
      do_req(1'b0, 32'h0008, 32'h0, 4'h0, rd, lat, ok);
      total += 3;
      if (!ok) begin bad++; $display("FAIL mid_post_accept got=0 exp=1"); end
      if (lat != LATENCY) begin bad++; $display("FAIL mid_post_latency got=%0d exp=%0d", lat, LATENCY); end
      if (rd !== 32'h12345678) begin bad++; $display("FAIL mid_post_rdata got=%h exp=12345678", rd); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte_merge();
      test_alias();
      test_backpressure();
      test_random();
      test_midreset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
